// File: rtl/sharp_update_scheduler.sv
// sharp_update_scheduler: dirty-line tracker and command sequencer for the LS013B7DH01 memory-LCD driver.
// Optional multi-line bursts are enabled by defining SHARP_SCHED_MULTILINE_EN.
module sharp_update_scheduler #(
    parameter int NUM_LINES = 168,
    parameter int VCOM_DIV  = 12000000,
    parameter int MAX_BURST = 8
) (
    input  logic       clk_12mhz,
    input  logic       rst_n,
    input  logic       mark_valid,
    input  logic [7:0] mark_line,
    input  logic       mark_all,
    input  logic       clear_req,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_type,
    output logic [7:0] cmd_line,
    output logic [7:0] cmd_count,
    output logic       cmd_vcom,
    output logic       vcom,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd3;
`ifdef SHARP_SCHED_MULTILINE_EN
    localparam logic [1:0] EXTEND = 2'd2;
`endif
    localparam logic [1:0] TYPE_VCOM  = 2'b00;
    localparam logic [1:0] TYPE_WRITE = 2'b01;
    localparam logic [1:0] TYPE_CLEAR = 2'b10;
    localparam int CW = $clog2(VCOM_DIV);
    localparam logic [CW-1:0] VCOM_LAST = CW'(VCOM_DIV - 1);
    localparam logic [7:0] LAST_LINE = 8'(NUM_LINES - 1);

    if (VCOM_DIV < 4 || MAX_BURST < 1) begin : g_bad_params
        $error("sharp_update_scheduler: VCOM_DIV must be >= 4 and MAX_BURST >= 1");
    end

    logic [1:0]           state, stateNext;
    logic [NUM_LINES-1:0] dirty, dirtyNext;
    logic [7:0]           ptr, ptrNext;
    logic [CW-1:0]        vcomCnt;
    logic                 clearPending, vcomPending, toggledSinceLoad;
    logic                 vcomWrap, accept, anyDirty, load;
    logic [1:0]           loadType;
    logic [7:0]           loadLine, loadCount;
    logic [8:0]           lastPlusOne;
`ifdef SHARP_SCHED_MULTILINE_EN
    logic [7:0]           runLen, runLenNext;
    logic [8:0]           extIdx;
    logic                 extHit;
    assign extIdx = 9'(ptr) + 9'(runLen);
    // lines past the panel end read as clean, so a burst never wraps
    assign extHit = runLen < 8'(MAX_BURST) && extIdx < 9'(NUM_LINES) && dirty[extIdx[7:0]];
`endif

    assign vcomWrap    = vcomCnt == VCOM_LAST;
    assign accept      = cmd_valid && cmd_ready;
    assign anyDirty    = |dirty;
    assign busy        = anyDirty || clearPending || vcomPending || cmd_valid;
    assign lastPlusOne = 9'(cmd_line) + 9'(cmd_count) - 9'd1;

    // Bitmap update: accepted writes clear their lines, then marks set bits so a mark always wins
    always_comb begin
        dirtyNext = dirty;
        if (accept && cmd_type == TYPE_WRITE)
            for (int i = 0; i < NUM_LINES; i++)
                if (i + 1 >= int'(cmd_line) && i + 1 < int'(cmd_line) + int'(cmd_count)) dirtyNext[i] = 1'b0;
        if (mark_all) dirtyNext = '1;
        if (mark_valid && mark_line < 8'(NUM_LINES)) dirtyNext[mark_line] = 1'b1;
    end

    // Scheduler decisions: which command to load next and where the scan pointer goes
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        load      = 1'b0;
        loadType  = TYPE_VCOM;
        loadLine  = 8'd0;
        loadCount = 8'd0;
`ifdef SHARP_SCHED_MULTILINE_EN
        runLenNext = runLen;
`endif
        case (state)
            IDLE: begin
                if (clearPending) begin
                    load     = 1'b1;
                    loadType = TYPE_CLEAR;
                end else if (anyDirty) begin
                    stateNext = SCAN;
                end else if (vcomPending) begin
                    load = 1'b1;
                end
            end
            SCAN: begin
                if (clearPending) begin
                    load     = 1'b1;
                    loadType = TYPE_CLEAR;
                end else if (!anyDirty) begin
                    stateNext = IDLE;
                end else if (dirty[ptr]) begin
`ifdef SHARP_SCHED_MULTILINE_EN
                    runLenNext = 8'd1;
                    stateNext  = EXTEND;
`else
                    load      = 1'b1;
                    loadType  = TYPE_WRITE;
                    loadLine  = ptr + 8'd1;
                    loadCount = 8'd1;
`endif
                end else begin
                    ptrNext = ptr == LAST_LINE ? 8'd0 : ptr + 8'd1;
                end
            end
`ifdef SHARP_SCHED_MULTILINE_EN
            EXTEND: begin
                if (extHit) begin
                    runLenNext = runLen + 8'd1;
                end else begin
                    load      = 1'b1;
                    loadType  = TYPE_WRITE;
                    loadLine  = ptr + 8'd1;
                    loadCount = runLen;
                end
            end
`endif
            ISSUE: begin
                if (accept) begin
                    stateNext = IDLE;
                    if (cmd_type == TYPE_WRITE)
                        ptrNext = lastPlusOne >= 9'(NUM_LINES) ? 8'd0 : lastPlusOne[7:0];
                end
            end
            default: stateNext = IDLE;
        endcase
        if (load) stateNext = ISSUE;
    end

    // Free-running VCOM divider; polarity flips on every wrap
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            vcomCnt <= '0;
            vcom    <= 1'b0;
        end else begin
            vcomCnt <= vcomWrap ? '0 : vcomCnt + 1'b1;
            vcom    <= vcomWrap ? ~vcom : vcom;
        end
    end

    // Pending work: new requests win over same-cycle acceptance
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            dirty            <= '0;
            clearPending     <= 1'b0;
            vcomPending      <= 1'b0;
            toggledSinceLoad <= 1'b0;
        end else begin
            dirty            <= dirtyNext;
            clearPending     <= clear_req ? 1'b1 : (accept && cmd_type == TYPE_CLEAR) ? 1'b0 : clearPending;
            vcomPending      <= vcomWrap ? 1'b1 : (accept && !toggledSinceLoad) ? 1'b0 : vcomPending;
            toggledSinceLoad <= load ? vcomWrap : (vcomWrap || toggledSinceLoad);
        end
    end

    // FSM state, scan pointer and the command register held stable until accepted
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 8'd0;
            cmd_valid <= 1'b0;
            cmd_type  <= TYPE_VCOM;
            cmd_line  <= 8'd0;
            cmd_count <= 8'd0;
            cmd_vcom  <= 1'b0;
`ifdef SHARP_SCHED_MULTILINE_EN
            runLen    <= 8'd0;
`endif
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
`ifdef SHARP_SCHED_MULTILINE_EN
            runLen <= runLenNext;
`endif
            if (load) begin
                cmd_valid <= 1'b1;
                cmd_type  <= loadType;
                cmd_line  <= loadLine;
                cmd_count <= loadCount;
                cmd_vcom  <= vcom;
            end else if (accept) begin
                cmd_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sharp_update_scheduler.sv
// tb_sharp_update_scheduler: directed table-driven bench for sharp_update_scheduler
module tb_sharp_update_scheduler;
    logic       clk_12mhz = 1'b0;
    logic       rst_n = 1'b0;
    logic       mark_valid = 1'b0, mark_all = 1'b0, clear_req = 1'b0, cmd_ready = 1'b0;
    logic [7:0] mark_line = 8'd0;
    logic       cmd_valid, cmd_vcom, vcom, busy;
    logic [1:0] cmd_type;
    logic [7:0] cmd_line, cmd_count;
    logic       zero = 1'b0;
    logic [7:0] zero8 = 8'd0;
    logic       vReady = 1'b1;
    logic       vValid, vCmdVcom, vVcom, vBusy;
    logic [1:0] vType;
    logic [7:0] vLine, vCount;
    int vecs = 0, miss = 0;

    sharp_update_scheduler #(.NUM_LINES(168), .VCOM_DIV(1000000), .MAX_BURST(8)) dut (
        .clk_12mhz(clk_12mhz), .rst_n(rst_n), .mark_valid(mark_valid), .mark_line(mark_line),
        .mark_all(mark_all), .clear_req(clear_req), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_line(cmd_line), .cmd_count(cmd_count), .cmd_vcom(cmd_vcom),
        .vcom(vcom), .busy(busy));

    sharp_update_scheduler #(.NUM_LINES(168), .VCOM_DIV(16), .MAX_BURST(8)) dutV (
        .clk_12mhz(clk_12mhz), .rst_n(rst_n), .mark_valid(zero), .mark_line(zero8),
        .mark_all(zero), .clear_req(zero), .cmd_valid(vValid), .cmd_ready(vReady),
        .cmd_type(vType), .cmd_line(vLine), .cmd_count(vCount), .cmd_vcom(vCmdVcom),
        .vcom(vVcom), .busy(vBusy));

    always #5 clk_12mhz = ~clk_12mhz;

`ifdef SHARP_SCHED_MULTILINE_EN
    localparam int BURST = 8;
    localparam int LAT = 4;
`else
    localparam int BURST = 1;
    localparam int LAT = 3;
`endif

    typedef struct {
        int line;
        bit expCmd;
        int expLine;
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge clk_12mhz);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic markOne(input int l);
        mark_valid = 1'b1;
        mark_line = 8'(l);
        tick();
        mark_valid = 1'b0;
    endtask

    task automatic waitValid(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (cmd_valid) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic waitIdle(input string nm);
        for (int i = 0; i < 10 && busy; i++) tick();
        chk(nm, busy, 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int n, nxt, expCnt;
        logic expV;
        tbl[0] = '{5, 1'b1, 6};
        tbl[1] = '{0, 1'b1, 1};
        tbl[2] = '{167, 1'b1, 168};
        tbl[3] = '{100, 1'b1, 101};
        tbl[4] = '{200, 1'b0, 0};

        doReset();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_cmd_type", cmd_type, 0);
        chk("rst_cmd_line", cmd_line, 0);
        chk("rst_cmd_count", cmd_count, 0);
        chk("rst_cmd_vcom", cmd_vcom, 0);
        chk("rst_vcom", vcom, 0);
        chk("rst_busy", busy, 0);

        markOne(0);
        for (int i = 1; i < LAT - 1; i++) tick();
        chk("latency_early", cmd_valid, 0);
        tick();
        chk("latency_valid", cmd_valid, 1);
        chk("latency_line", cmd_line, 1);
        cmd_ready = 1'b1;
        tick();
        waitIdle("latency_idle");

        for (int v = 0; v < 5; v++) begin
            markOne(tbl[v].line);
            if (tbl[v].expCmd) begin
                waitValid(400, ok);
                chk("tbl_timeout", ok, 1);
                chk("tbl_type", cmd_type, 1);
                chk("tbl_line", cmd_line, tbl[v].expLine);
                chk("tbl_count", cmd_count, 1);
                chk("tbl_cmd_vcom", cmd_vcom, 0);
                tick();
                waitIdle("tbl_idle");
            end else begin
                waitValid(50, ok);
                chk("tbl_ignored_cmd", ok, 0);
                chk("tbl_ignored_busy", busy, 0);
            end
        end

        doReset();
        cmd_ready = 1'b0;
        markOne(10);
        markOne(2);
        waitValid(50, ok);
        chk("hold_timeout", ok, 1);
        chk("hold_first_line", cmd_line, 3);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(cmd_valid && cmd_line == 8'd3 && cmd_count == 8'd1 && cmd_type == 2'b01)) n++;
        end
        chk("hold_unstable_cycles", n, 0);
        cmd_ready = 1'b1;
        tick();
        waitValid(50, ok);
        chk("hold_second_timeout", ok, 1);
        chk("hold_second_line", cmd_line, 11);
        tick();
        waitIdle("hold_idle");

        doReset();
        for (int l = 50; l <= 60; l++) markOne(l);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        waitValid(300, ok);
        chk("clr_timeout", ok, 1);
        chk("clr_type", cmd_type, 2);
        chk("clr_line", cmd_line, 0);
        chk("clr_count", cmd_count, 0);
        tick();
        nxt = 51;
        for (int g = 0; g < 20 && nxt <= 61; g++) begin
            expCnt = (62 - nxt < BURST) ? 62 - nxt : BURST;
            waitValid(400, ok);
            chk("clr_wr_timeout", ok, 1);
            if (!ok) break;
            chk("clr_wr_type", cmd_type, 1);
            chk("clr_wr_line", cmd_line, nxt);
            chk("clr_wr_count", cmd_count, expCnt);
            nxt += expCnt;
            tick();
        end
        waitIdle("clr_idle");

        doReset();
        cmd_ready = 1'b0;
        markOne(7);
        waitValid(50, ok);
        chk("remark_timeout", ok, 1);
        chk("remark_first_line", cmd_line, 8);
        cmd_ready = 1'b1;
        mark_valid = 1'b1;
        mark_line = 8'd7;
        tick();
        mark_valid = 1'b0;
        chk("remark_busy", busy, 1);
        waitValid(400, ok);
        chk("remark_second_timeout", ok, 1);
        chk("remark_second_line", cmd_line, 8);
        tick();
        waitIdle("remark_idle");

        doReset();
        mark_all = 1'b1;
        tick();
        mark_all = 1'b0;
        for (int i = 0; i < 168 / BURST; i++) begin
            waitValid(400, ok);
            chk("all_timeout", ok, 1);
            if (!ok) break;
            chk("all_line", cmd_line, 1 + i * BURST);
            chk("all_count", cmd_count, BURST);
            tick();
        end
        waitValid(20, ok);
        chk("all_extra_cmd", ok, 0);
        chk("all_idle", busy, 0);

        cmd_ready = 1'b0;
        markOne(3);
        waitValid(50, ok);
        chk("midrst_timeout", ok, 1);
        @(negedge clk_12mhz);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", cmd_valid, 0);
        chk("midrst_busy", busy, 0);
        tick();
        rst_n = 1'b1;

        expV = 1'b0;
        n = 0;
        while (vVcom === expV && n < 40) begin
            tick();
            n++;
        end
        expV = ~expV;
        chk("vcom_first_toggle", vVcom, expV);
        for (int t = 0; t < 3; t++) begin
            n = 0;
            while (!vValid && n < 8) begin
                tick();
                n++;
            end
            chk("vcom_cmd_valid", vValid, 1);
            chk("vcom_cmd_type", vType, 0);
            chk("vcom_cmd_vcom", vCmdVcom, expV);
            chk("vcom_cmd_line", vLine, 0);
            chk("vcom_cmd_count", vCount, 0);
            while (vVcom === expV && n < 40) begin
                tick();
                n++;
            end
            expV = ~expV;
            chk("vcom_period", n, 16);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
